// File: rtl/tpu_vector_loader.sv
// tpu_vector_loader: assembles a 128-element activation vector and a
// 128-element weight vector from one byte stream and presents both as flat
// buses to the MAC array. The activation bank is reused for every neuron of a
// layer; only the weight bank is reloaded per neuron.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_FILL    | accepting bytes into either bank, s_ready high
// ST_PRESENT | both banks complete, vec_valid high, waiting for vec_ready
module tpu_vector_loader #(
    parameter int VEC_LEN = 128,
    parameter int DATA_W  = 8,
    parameter int NEURONS = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid,
    input  logic [DATA_W-1:0]            s_data,
    input  logic                         s_sel,
    output logic                         s_ready,
    output logic [VEC_LEN*DATA_W-1:0]    data_in1,
    output logic [VEC_LEN*DATA_W-1:0]    data_in2,
    output logic                         vec_valid,
    input  logic                         vec_ready,
    output logic [$clog2(NEURONS)-1:0]   neuron_idx,
    output logic                         layer_done,
    output logic                         ovf_err
);

    localparam int CNT_W = $clog2(VEC_LEN + 1);
    localparam int IDX_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int NI_W  = $clog2(NEURONS);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(VEC_LEN);
    localparam logic [NI_W-1:0]  NI_LAST  = NI_W'(NEURONS - 1);

    typedef enum logic {ST_FILL, ST_PRESENT} state_t;

    state_t                          r_state, w_state_nxt;
    logic [CNT_W-1:0]                r_act_cnt, r_wgt_cnt;
    logic [CNT_W-1:0]                w_act_cnt_nxt, w_wgt_cnt_nxt;
    logic [NI_W-1:0]                 r_neuron_idx, w_neuron_idx_nxt;
    logic                            r_layer_done, w_layer_done_nxt;
    logic                            r_ovf_err, w_ovf_set;
    logic                            w_act_we, w_wgt_we;
    logic                            w_accept, w_act_full, w_wgt_full;
    logic [VEC_LEN-1:0][DATA_W-1:0]  r_act_bank, r_wgt_bank;

    assign w_accept   = s_valid && (r_state == ST_FILL);
    assign w_act_full = (r_act_cnt == CNT_FULL);
    assign w_wgt_full = (r_wgt_cnt == CNT_FULL);

    // State, counters and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_FILL;
            r_act_cnt    <= '0;
            r_wgt_cnt    <= '0;
            r_neuron_idx <= '0;
            r_layer_done <= 1'b0;
            r_ovf_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_act_cnt    <= w_act_cnt_nxt;
            r_wgt_cnt    <= w_wgt_cnt_nxt;
            r_neuron_idx <= w_neuron_idx_nxt;
            r_layer_done <= w_layer_done_nxt;
            r_ovf_err    <= r_ovf_err | w_ovf_set;
        end
    end

    // Next-state, counter and bank-write decode. The PRESENT transition looks
    // at the next counter values so a completing byte and an already-full
    // bank are treated alike.
    always_comb begin
        w_state_nxt      = r_state;
        w_act_cnt_nxt    = r_act_cnt;
        w_wgt_cnt_nxt    = r_wgt_cnt;
        w_neuron_idx_nxt = r_neuron_idx;
        w_layer_done_nxt = 1'b0;
        w_ovf_set        = 1'b0;
        w_act_we         = 1'b0;
        w_wgt_we         = 1'b0;
        case (r_state)
            ST_FILL: begin
                if (w_accept) begin
                    if (!s_sel) begin
                        if (w_act_full) begin
                            w_ovf_set = 1'b1;
                        end else begin
                            w_act_we      = 1'b1;
                            w_act_cnt_nxt = r_act_cnt + 1'b1;
                        end
                    end else begin
                        if (w_wgt_full) begin
                            w_ovf_set = 1'b1;
                        end else begin
                            w_wgt_we      = 1'b1;
                            w_wgt_cnt_nxt = r_wgt_cnt + 1'b1;
                        end
                    end
                end
                if ((w_act_cnt_nxt == CNT_FULL) && (w_wgt_cnt_nxt == CNT_FULL)) begin
                    w_state_nxt = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (vec_ready) begin
                    w_state_nxt   = ST_FILL;
                    w_wgt_cnt_nxt = '0;
                    if (r_neuron_idx == NI_LAST) begin
                        w_neuron_idx_nxt = '0;
                        w_act_cnt_nxt    = '0;
                        w_layer_done_nxt = 1'b1;
                    end else begin
                        w_neuron_idx_nxt = r_neuron_idx + 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_FILL;
        endcase
    end

    // Bank storage; counter rewinds leave old contents in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_act_bank <= '0;
            r_wgt_bank <= '0;
        end else begin
            if (w_act_we) r_act_bank[r_act_cnt[IDX_W-1:0]] <= s_data;
            if (w_wgt_we) r_wgt_bank[r_wgt_cnt[IDX_W-1:0]] <= s_data;
        end
    end

    assign s_ready    = (r_state == ST_FILL);
    assign vec_valid  = (r_state == ST_PRESENT);
    assign data_in1   = r_act_bank;
    assign data_in2   = r_wgt_bank;
    assign neuron_idx = r_neuron_idx;
    assign layer_done = r_layer_done;
    assign ovf_err    = r_ovf_err;

endmodule

// File: tb/tb_tpu_vector_loader.sv
// Bench for tpu_vector_loader: table-driven phases, hand-written corner
// sequences and a randomized run, all compared against a byte-level model.
module tb_tpu_vector_loader;

    localparam int VL  = 128;
    localparam int DW  = 8;
    localparam int NEU = 10;
    localparam int BW  = VL * DW;
    localparam int NW  = $clog2(NEU);

    localparam int M_BYTES = 0;
    localparam int M_HS    = 1;
    localparam int M_IL    = 2;
    localparam int M_RST   = 3;

    logic          clk, clk_en, rst;
    logic          s_valid, s_sel, s_ready, vec_valid, vec_ready;
    logic [DW-1:0] s_data;
    logic [BW-1:0] data_in1, data_in2;
    logic [NW-1:0] neuron_idx;
    logic          layer_done, ovf_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: plain byte arrays packed as buses, counts of bytes held.
    logic [BW-1:0] m_act, m_wgt;
    int            m_na, m_nw, m_nidx;
    bit            m_present, m_done, m_ovf;

    typedef struct {
        int         mode;
        bit         sel;
        int         count;
        logic [7:0] base;
        logic [7:0] inc;
        bit         exp_valid;
        int         exp_nidx;
        bit         exp_ovf;
    } vec_t;

    vec_t tbl[14];

    tpu_vector_loader #(.VEC_LEN(VL), .DATA_W(DW), .NEURONS(NEU)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_sel      (s_sel),
        .s_ready    (s_ready),
        .data_in1   (data_in1),
        .data_in2   (data_in2),
        .vec_valid  (vec_valid),
        .vec_ready  (vec_ready),
        .neuron_idx (neuron_idx),
        .layer_done (layer_done),
        .ovf_err    (ovf_err)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_bus(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            for (int k = 0; k < VL; k++) begin
                if (act[k*DW +: DW] !== exp[k*DW +: DW]) begin
                    $display("FAIL %s: elem %0d got %02h want %02h", name, k,
                             act[k*DW +: DW], exp[k*DW +: DW]);
                    break;
                end
            end
        end
    endtask

    task automatic model_reset();
        m_act = '0; m_wgt = '0;
        m_na = 0; m_nw = 0; m_nidx = 0;
        m_present = 0; m_done = 0; m_ovf = 0;
    endtask

    task automatic model_step(input bit v, input bit sel, input logic [7:0] d, input bit vr);
        bit done_n;
        done_n = 0;
        if (!m_present) begin
            if (v) begin
                if (!sel) begin
                    if (m_na < VL) begin m_act[m_na*DW +: DW] = d; m_na++; end
                    else m_ovf = 1;
                end else begin
                    if (m_nw < VL) begin m_wgt[m_nw*DW +: DW] = d; m_nw++; end
                    else m_ovf = 1;
                end
            end
            if (m_na == VL && m_nw == VL) m_present = 1;
        end else if (vr) begin
            m_present = 0;
            m_nw = 0;
            if (m_nidx == NEU - 1) begin
                m_nidx = 0; m_na = 0; done_n = 1;
            end else begin
                m_nidx++;
            end
        end
        m_done = done_n;
    endtask

    task automatic check_all(input string tag);
        chk({tag, " s_ready"},    32'(s_ready),    32'(!m_present));
        chk({tag, " vec_valid"},  32'(vec_valid),  32'(m_present));
        chk({tag, " neuron_idx"}, 32'(neuron_idx), 32'(m_nidx));
        chk({tag, " layer_done"}, 32'(layer_done), 32'(m_done));
        chk({tag, " ovf_err"},    32'(ovf_err),    32'(m_ovf));
        chk_bus({tag, " data_in1"}, data_in1, m_act);
        chk_bus({tag, " data_in2"}, data_in2, m_wgt);
    endtask

    task automatic step(input bit v, input bit sel, input logic [7:0] d, input bit vr, input string tag);
        s_valid = v; s_sel = sel; s_data = d; vec_ready = vr;
        @(posedge clk);
        model_step(v, sel, d, vr);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        s_valid = 0; vec_ready = 0;
        #2 rst = 1'b1;
        #2;
        model_reset();
        check_all("reset");
        #1 rst = 1'b0;
    endtask

    task automatic chk_ramp(input string tag);
        logic [BW-1:0] e1, e2;
        for (int k = 0; k < VL; k++) begin
            e1[k*DW +: DW] = 8'(k);
            e2[k*DW +: DW] = 8'(8'h80 + k);
        end
        chk_bus({tag, " ramp act"}, data_in1, e1);
        chk_bus({tag, " ramp wgt"}, data_in2, e2);
    endtask

    task automatic run_table(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            case (tbl[i].mode)
                M_BYTES: for (int j = 0; j < tbl[i].count; j++)
                    step(1, tbl[i].sel, tbl[i].base + 8'(j) * tbl[i].inc, 0, "tbl bytes");
                M_HS: step(0, 0, 8'h00, 1, "tbl hs");
                M_IL: for (int j = 0; j < tbl[i].count; j++) begin
                    step(1, j[0], j[0] ? 8'(8'h80 + j / 2) : 8'(j / 2), 0, "tbl il");
                    if (j == tbl[i].count - 2) chk("il early vec_valid", 32'(vec_valid), 32'd0);
                end
                default: do_reset();
            endcase
            chk($sformatf("tbl[%0d] vec_valid", i), 32'(vec_valid),  32'(tbl[i].exp_valid));
            chk($sformatf("tbl[%0d] neuron_idx", i), 32'(neuron_idx), 32'(tbl[i].exp_nidx));
            chk($sformatf("tbl[%0d] ovf_err", i), 32'(ovf_err),    32'(tbl[i].exp_ovf));
        end
    endtask

    initial begin
        logic [BW-1:0] e11;
        int guard;

        tbl[0]  = '{M_BYTES, 1'b0, 128, 8'h00, 8'h01, 1'b0, 0, 1'b0};
        tbl[1]  = '{M_BYTES, 1'b1, 128, 8'h80, 8'h01, 1'b1, 0, 1'b0};
        tbl[2]  = '{M_HS,    1'b0,   1, 8'h00, 8'h00, 1'b0, 1, 1'b0};
        tbl[3]  = '{M_BYTES, 1'b1, 128, 8'h11, 8'h00, 1'b1, 1, 1'b0};
        tbl[4]  = '{M_RST,   1'b0,   0, 8'h00, 8'h00, 1'b0, 0, 1'b0};
        tbl[5]  = '{M_IL,    1'b0, 256, 8'h00, 8'h00, 1'b1, 0, 1'b0};
        tbl[6]  = '{M_HS,    1'b0,   1, 8'h00, 8'h00, 1'b0, 1, 1'b0};
        tbl[7]  = '{M_BYTES, 1'b0,   1, 8'hEE, 8'h00, 1'b0, 1, 1'b1};
        tbl[8]  = '{M_RST,   1'b0,   0, 8'h00, 8'h00, 1'b0, 0, 1'b0};
        tbl[9]  = '{M_BYTES, 1'b0, 129, 8'h20, 8'h01, 1'b0, 0, 1'b1};
        tbl[10] = '{M_BYTES, 1'b1, 128, 8'h40, 8'h01, 1'b1, 0, 1'b1};
        tbl[11] = '{M_HS,    1'b0,   1, 8'h00, 8'h00, 1'b0, 1, 1'b1};
        tbl[12] = '{M_BYTES, 1'b1, 128, 8'h55, 8'h00, 1'b1, 1, 1'b1};
        tbl[13] = '{M_RST,   1'b0,   0, 8'h00, 8'h00, 1'b0, 0, 1'b0};

        clk_en = 1'b1;
        rst = 1'b1;
        s_valid = 0; s_sel = 0; s_data = '0; vec_ready = 0;
        model_reset();
        #12;
        @(negedge clk);
        check_all("por");
        rst = 1'b0;

        // Layer load, handshake and activation reuse.
        run_table(0, 1);
        chk("act elem0",   32'(data_in1[7:0]),       32'h00);
        chk("act elem127", 32'(data_in1[1023:1016]), 32'h7F);
        chk("wgt elem0",   32'(data_in2[7:0]),       32'h80);
        chk_ramp("sorted");
        run_table(2, 3);
        for (int k = 0; k < VL; k++) e11[k*DW +: DW] = 8'h11;
        chk_bus("reuse wgt 0x11", data_in2, e11);
        for (int k = 0; k < VL; k++) e11[k*DW +: DW] = 8'(k);
        chk_bus("reuse act kept", data_in1, e11);

        // Remaining neurons of the layer; each handshake carries a pending byte.
        for (int n = 2; n < NEU; n++) begin
            step(1, 1, 8'($urandom), 1, "hs");
            chk("s_ready after hs", 32'(s_ready), 32'd1);
            guard = 0;
            while (!m_present && guard < 2000) begin
                step($urandom_range(0, 3) != 0, 1, 8'($urandom), 1'($urandom_range(0, 1)), "wload");
                guard++;
            end
            chk("wload bound", 32'(guard < 2000), 32'd1);
        end
        chk("last neuron idx", 32'(neuron_idx), 32'd9);
        chk("last neuron valid", 32'(vec_valid), 32'd1);
        step(0, 0, 8'h00, 1, "hs10");
        chk("wrap layer_done", 32'(layer_done), 32'd1);
        chk("wrap neuron_idx", 32'(neuron_idx), 32'd0);
        step(0, 0, 8'h00, 0, "post wrap");
        chk("layer_done pulse", 32'(layer_done), 32'd0);
        for (int j = 0; j < VL; j++) step(1, 1, 8'($urandom), 0, "wgt only");
        chk("wgt only no valid", 32'(vec_valid), 32'd0);
        for (int j = 0; j < VL; j++) step(1, 0, 8'($urandom), 0, "new act");
        chk("new act valid", 32'(vec_valid), 32'd1);

        // Asynchronous reset while the clock is parked low, DUT in PRESENT.
        @(negedge clk);
        clk_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("async rst");
        chk("async s_ready", 32'(s_ready), 32'd1);
        #3 rst = 1'b0;
        #2 clk_en = 1'b1;

        // Interleaved load and overflow behaviour.
        run_table(4, 13);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++)
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 8'($urandom),
                 $urandom_range(0, 2) == 0, "rand");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tpu_vector_loader.md
# tpu_vector_loader

Byte-serial operand loader that sits directly upstream of the 128-lane Float8 multiply-accumulate array. It assembles an activation vector and a weight vector, each 128 × 8 bit, from a single byte stream and presents them as two flat 1024-bit buses. The array then computes one neuron's dot product. The activation vector is retained across all neurons of a layer, and only the weight vector is reloaded per neuron.

## Interface
Parameters:
- `VEC_LEN`, default 128: elements per vector.
- `DATA_W`, default 8: bits per element (Float8).
- `NEURONS`, default 10: neurons per layer (dot products per activation load).

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `s_valid`, input, 1: stream byte valid.
- `s_data`, input, DATA_W: stream byte.
- `s_sel`, input, 1: target bank; 0 = activation, 1 = weight.
- `s_ready`, output, 1: loader accepts a byte.
- `data_in1`, output, VEC_LEN*DATA_W: activation bank, element k at bits [k*DATA_W +: DATA_W].
- `data_in2`, output, VEC_LEN*DATA_W: weight bank, same packing.
- `vec_valid`, output, 1: both banks complete; buses stable.
- `vec_ready`, input, 1: consumer has sampled the dot product.
- `neuron_idx`, output, $clog2(NEURONS): index of the neuron currently presented or being loaded.
- `layer_done`, output, 1: one-cycle pulse after the last neuron of a layer is consumed.
- `ovf_err`, output, 1: sticky; a byte was written to an already-full bank.

## Operation
- State machine has two states, FILL and PRESENT. Reset state is FILL.
- Counters:
  - `act_cnt` and `wgt_cnt` each run 0..VEC_LEN.
  - `neuron_idx` runs 0..NEURONS-1.
- FILL state:
  - `s_ready` = 1 and does not depend on `s_valid` or `s_sel`.
  - Each accepted byte (`s_valid && s_ready`) is written to element `act_cnt` of the activation bank (sel=0) or element `wgt_cnt` of the weight bank (sel=1); that counter then increments.
  - If the selected counter is already VEC_LEN, the byte is accepted and discarded, and `ovf_err` is set. `ovf_err` is cleared only by reset.
  - Sel=0 and sel=1 bytes may be freely interleaved.
- FILL → PRESENT occurs on the edge where both counters equal VEC_LEN, whether they reach it through a byte accepted on that edge or already hold it.
- PRESENT state:
  - `vec_valid` = 1 and `s_ready` = 0.
  - Both banks are held constant.
  - `vec_ready` is ignored in FILL.
- Handshake in PRESENT is `vec_ready` = 1. On that edge:
  - `wgt_cnt` ← 0 and the state returns to FILL.
  - If `neuron_idx` < NEURONS-1: `neuron_idx` increments; `act_cnt` is kept, so the activation bank is reused.
  - If `neuron_idx` = NEURONS-1: `neuron_idx` ← 0 and `act_cnt` ← 0; `layer_done` pulses high for the following cycle.
- Counter resets do not clear bank contents. Elements are overwritten by new bytes, and bus values are meaningful only while `vec_valid` = 1.
- Asserting reset at any point, including mid-fill or during PRESENT, immediately returns all state to reset values. Any partial vector is discarded.

## Timing
- Reset values:
  - `s_ready` = 1, `vec_valid` = 0, `layer_done` = 0, `ovf_err` = 0, `neuron_idx` = 0.
  - Both banks are all-zero, so `data_in1` = `data_in2` = 0.
  - Both counters = 0.
- All outputs are registered or decoded from state only; there are no combinational input-to-output paths.
- A byte accepted on edge N appears on the bus from cycle N+1.
- The edge completing the second bank sets `vec_valid` = 1 in the following cycle.
  - First neuron of a layer: minimum 2*VEC_LEN accepted bytes.
  - Subsequent neurons: VEC_LEN weight bytes.
- `vec_valid` falls and `s_ready` rises in the cycle after the handshake. With `s_valid` held high, the next weight byte is accepted that cycle, giving no dead cycle.
- `vec_ready` held high continuously consumes exactly one vector per PRESENT entry.

## Test plan
- **Reset:** assert `rst` mid-cycle with `clk` stopped → all outputs reach reset values without a clock edge; `s_ready` = 1.
- **Layer load:** 128 activation bytes 0x00..0x7F, then 128 weight bytes 0x80..0xFF, back-to-back → `vec_valid` rises on the cycle after the 256th accept.
  - `data_in1[7:0]` = 0x00, `data_in1[1023:1016]` = 0x7F, `data_in2[7:0]` = 0x80.
  - `neuron_idx` = 0.
- **Interleave:** alternate sel 0/1 each byte for 256 bytes → same bus contents as sorted loading; `vec_valid` only after the 256th byte.
- **Neuron reuse:** after the handshake, send only 128 weight bytes of 0x11 → `vec_valid` with `data_in1` unchanged, `data_in2` all 0x11, `neuron_idx` = 1.
- **Layer wrap:** complete 10 neurons → `layer_done` = 1 for exactly one cycle after the 10th handshake; `neuron_idx` = 0.
  - The next vector requires 128 new activation bytes; sending only weight bytes leaves `vec_valid` low.
- **Overflow:** send 129 activation bytes → byte 129 is accepted and dropped; `ovf_err` = 1 and stays set across later vectors until `rst`.
